mem_stage_lat: RTL and testbench

Parametrised memory-access pipeline stage: sits between EX/MEM and WB in the 5-stage core. Holds an internal data memory with byte/halfword/word loads and stores (sign or zero extension) and a configurable multi-cycle access latency with an upstream stall handshake. Selects the register write-back value and registers it into the MEM/WB outputs with a valid bit and flush support.

---
 rtl/mem_stage_lat_if.sv | 46 ++++
 rtl/mem_stage_lat.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage_lat.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lat_if.sv
// mem_stage_lat_if: EX/MEM request bundle and MEM/WB result bundle
// master = upstream pipeline side, slave = mem_stage_lat
interface mem_stage_lat_if #(
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_size;
  logic             mem_unsigned;
  logic [31:0]      alu_s;
  logic [31:0]      mem_wdata;
  logic [REG_W-1:0] write_reg;
  logic             reg_write;
  logic [1:0]       mem_to_reg;
  logic [31:0]      pc_plus4;
  logic             lu_op;
  logic [31:0]      lu_data;
  logic             flush;
  logic             stall;
  logic             wb_valid;
  logic             wb_reg_write;
  logic [REG_W-1:0] wb_write_reg;
  logic [31:0]      wb_data;
  logic             misalign;

  modport master (
    output in_valid, mem_read, mem_write,
    output mem_size, mem_unsigned,
    output alu_s, mem_wdata, write_reg,
    output reg_write, mem_to_reg, pc_plus4,
    output lu_op, lu_data, flush,
    input  stall, wb_valid, wb_reg_write,
    input  wb_write_reg, wb_data, misalign
  );

  modport slave (
    input  in_valid, mem_read, mem_write,
    input  mem_size, mem_unsigned,
    input  alu_s, mem_wdata, write_reg,
    input  reg_write, mem_to_reg, pc_plus4,
    input  lu_op, lu_data, flush,
    output stall, wb_valid, wb_reg_write,
    output wb_write_reg, wb_data, misalign
  );
endinterface

// File: rtl/mem_stage_lat.sv
// mem_stage_lat: data memory stage with multi-cycle access and MEM/WB reg
// MEM_STAGE_MISALIGN_EN: drop misaligned half/word accesses, pulse misalign
module mem_stage_lat #(
  parameter int DEPTH   = 1024,
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  mem_stage_lat_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
  localparam bit MULTI = (MEM_LAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           stateNxt;
  logic [2:0]       cnt;
  logic [2:0]       cntNxt;
  logic             stallC;
  logic             done;
  logic             isMem;
  logic             misal;
  logic             commit;
  logic [AW-1:0]    idx;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wd;
  logic [31:0]      rword;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [31:0]      ldata;
  logic [31:0]      wbVal;
  logic             wbValid;
  logic             wbRegWrite;
  logic [REG_W-1:0] wbWriteReg;
  logic [31:0]      wbData;
  logic             misalignQ;
  logic             unusedBits;

  logic [31:0] mem [DEPTH];

  assign isMem = bus.mem_read | bus.mem_write;
  assign idx   = bus.alu_s[AW+1:2];
  assign lane  = bus.alu_s[1:0];
  assign unusedBits = ^bus.alu_s[31:AW+2];

`ifdef MEM_STAGE_MISALIGN_EN
  // Half needs an even address, word needs a 4-byte aligned one
  always_comb begin
    misal = 1'b0;
    if (isMem) begin
      unique case (1'b1)
        bus.mem_size == 2'b00: misal = 1'b0;
        bus.mem_size == 2'b01: misal = lane[0];
        default:               misal = (lane != 2'b00);
      endcase
    end
  end
`else
  assign misal = 1'b0;
`endif

  // Access sequencing: IDLE accepts, BUSY counts out the latency
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    stallC   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        cntNxt = '0;
        if (bus.in_valid && !bus.flush) begin
          if (isMem && MULTI) begin
            stateNxt = BUSY;
            cntNxt   = 3'd1;
            stallC   = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          stateNxt = IDLE;
          cntNxt   = '0;
        end else if (cnt == LAST) begin
          stateNxt = IDLE;
          cntNxt   = '0;
          done     = 1'b1;
        end else begin
          cntNxt = cnt + 3'd1;
          stallC = 1'b1;
        end
      end
      default: begin
        stateNxt = IDLE;
        cntNxt   = '0;
      end
    endcase
  end

  assign commit = done && bus.mem_write && !misal;

  // Byte enables and lane-replicated store data
  always_comb begin
    be = 4'b0000;
    wd = bus.mem_wdata;
    unique case (1'b1)
      bus.mem_size == 2'b00: begin
        be[lane] = 1'b1;
        wd = {4{bus.mem_wdata[7:0]}};
      end
      bus.mem_size == 2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.mem_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = bus.mem_wdata;
      end
    endcase
  end

  // Store commit on the final access edge
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
      end
    end
  end

  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = rword[{lane[1], 4'b0000} +: 16];

  // Load extraction and extension
  always_comb begin
    ldata = rword;
    unique case (1'b1)
      bus.mem_size == 2'b00:
        ldata = bus.mem_unsigned ? {24'b0, rbyte}
                                 : {{24{rbyte[7]}}, rbyte};
      bus.mem_size == 2'b01:
        ldata = bus.mem_unsigned ? {16'b0, rhalf}
                                 : {{16{rhalf[15]}}, rhalf};
      default:
        ldata = rword;
    endcase
  end

  // Write-back source select, lui overrides everything
  always_comb begin
    wbVal = bus.alu_s;
    if (bus.lu_op) begin
      wbVal = bus.lu_data;
    end else begin
      unique case (1'b1)
        bus.mem_to_reg[1]:          wbVal = bus.pc_plus4;
        bus.mem_to_reg == 2'b01:    wbVal = ldata;
        default:                    wbVal = bus.alu_s;
      endcase
    end
  end

  // State and MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
      wbWriteReg <= '0;
      wbData     <= '0;
      misalignQ  <= 1'b0;
    end else begin
      state      <= stateNxt;
      cnt        <= cntNxt;
      wbValid    <= done && !misal;
      wbRegWrite <= done && !misal && bus.reg_write;
      misalignQ  <= done && misal;
      if (done && !misal) begin
        wbWriteReg <= bus.write_reg;
        wbData     <= wbVal;
      end
    end
  end

  assign bus.stall        = stallC;
  assign bus.wb_valid     = wbValid;
  assign bus.wb_reg_write = wbRegWrite;
  assign bus.wb_write_reg = wbWriteReg;
  assign bus.wb_data      = wbData;
  assign bus.misalign     = misalignQ;
endmodule

// File: tb/tb_mem_stage_lat.sv
// tb_mem_stage_lat: random + directed checks of mem_stage_lat
// three instances with MEM_LAT 1, 3 and 4 against a byte-array model
`timescale 1ns/1ps
module tb_mem_stage_lat;
  localparam int DEPTH = 64;
  localparam int REG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld = 0, rd = 0, wr = 0, uns = 0;
  logic [1:0]  sz = 0, m2 = 0;
  logic [31:0] alu = 0, wdat = 0, pc4 = 0, ludat = 0;
  logic [4:0]  wreg = 0;
  logic        regw = 0, luop = 0, fl = 0;
  int          sel = 0;

  logic        stallA [3];
  logic        validA [3];
  logic        rwA    [3];
  logic [4:0]  regA   [3];
  logic [31:0] dataA  [3];
  logic        misA   [3];

  logic        stallS, validS, rwS, misS;
  logic [4:0]  regS;
  logic [31:0] dataS;

  int nErr = 0;
  int nChk = 0;

  logic [7:0] mm [3][256];

  mem_stage_lat_if #(.REG_W(REG_W)) bi [3] ();

  for (genvar g = 0; g < 3; g++) begin : gI
    mem_stage_lat #(
      .DEPTH(DEPTH),
      .REG_W(REG_W),
      .MEM_LAT((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u (
      .clk(clk),
      .rst(rst),
      .bus(bi[g].slave)
    );
    assign bi[g].in_valid     = vld && (sel == g);
    assign bi[g].flush        = fl && (sel == g);
    assign bi[g].mem_read     = rd;
    assign bi[g].mem_write    = wr;
    assign bi[g].mem_size     = sz;
    assign bi[g].mem_unsigned = uns;
    assign bi[g].alu_s        = alu;
    assign bi[g].mem_wdata    = wdat;
    assign bi[g].write_reg    = wreg;
    assign bi[g].reg_write    = regw;
    assign bi[g].mem_to_reg   = m2;
    assign bi[g].pc_plus4     = pc4;
    assign bi[g].lu_op        = luop;
    assign bi[g].lu_data      = ludat;
    assign stallA[g] = bi[g].stall;
    assign validA[g] = bi[g].wb_valid;
    assign rwA[g]    = bi[g].wb_reg_write;
    assign regA[g]   = bi[g].wb_write_reg;
    assign dataA[g]  = bi[g].wb_data;
    assign misA[g]   = bi[g].misalign;
  end

  always_comb begin
    stallS = stallA[0]; validS = validA[0]; rwS = rwA[0];
    regS = regA[0]; dataS = dataA[0]; misS = misA[0];
    case (sel)
      1: begin
        stallS = stallA[1]; validS = validA[1]; rwS = rwA[1];
        regS = regA[1]; dataS = dataA[1]; misS = misA[1];
      end
      2: begin
        stallS = stallA[2]; validS = validA[2]; rwS = rwA[2];
        regS = regA[2]; dataS = dataA[2]; misS = misA[2];
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 4;
  endfunction

  function automatic int baseAddr(input logic [31:0] a, input logic [1:0] z);
    int x;
    x = int'(a[7:0]);
    if (z == 2'd1) x = x - (x % 2);
    else if (z[1]) x = x - (x % 4);
    return x;
  endfunction

  function automatic logic isMis(input logic m, input logic [1:0] z,
                                 input logic [31:0] a);
`ifdef MEM_STAGE_MISALIGN_EN
    if (!m) return 1'b0;
    if (z == 2'd1) return a[0];
    if (z[1]) return (a[1:0] != 2'b00);
    return 1'b0;
`else
    return 1'b0 & m & z[0] & a[0];
`endif
  endfunction

  function automatic logic [31:0] mLoad(input int s, input logic [1:0] z,
                                        input logic u,
                                        input logic [31:0] a);
    int x;
    logic [31:0] v;
    x = baseAddr(a, z);
    if (z == 2'd0) begin
      v = {24'b0, mm[s][x]};
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (z == 2'd1) begin
      v = {16'b0, mm[s][x+1], mm[s][x]};
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mm[s][x+3], mm[s][x+2], mm[s][x+1], mm[s][x]};
    end
    return v;
  endfunction

  task automatic mStore(input int s, input logic [1:0] z,
                        input logic [31:0] a, input logic [31:0] d);
    int x, nb;
    x = baseAddr(a, z);
    nb = (z == 2'd0) ? 1 : (z == 2'd1) ? 2 : 4;
    for (int i = 0; i < nb; i++) mm[s][x+i] = d[8*i +: 8];
  endtask

  task automatic issue(input int s, input logic r, input logic w,
                       input logic [1:0] z, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] mt, input logic lu,
                       input logic [31:0] ld, input logic [4:0] rg,
                       input logic rw, input logic [31:0] pc);
    int n, expN;
    logic mis, ev;
    logic [31:0] ed;
    sel = s; vld = 1; rd = r; wr = w; sz = z; uns = u;
    alu = a; wdat = d; m2 = mt; luop = lu; ludat = ld;
    wreg = rg; regw = rw; pc4 = pc; fl = 0;
    #1;
    expN = ((r || w) && lat(s) > 1) ? lat(s) - 1 : 0;
    n = 0;
    while (stallS && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      chk("busyValid", 32'(validS), 32'd0);
      chk("busyRegWr", 32'(rwS), 32'd0);
    end
    chk("stallCycles", 32'(n), 32'(expN));
    @(posedge clk);
    #1;
    mis = isMis(r || w, z, a);
    ev = !mis;
    if (lu) ed = ld;
    else if (mt[1]) ed = pc;
    else if (mt == 2'b01) ed = mLoad(s, z, u, a);
    else ed = a;
    chk("wbValid", 32'(validS), 32'(ev));
    chk("misalign", 32'(misS), 32'(mis));
    chk("wbRegWr", 32'(rwS), 32'(ev && rw));
    if (ev) begin
      chk("wbReg", 32'(regS), 32'(rg));
      chk("wbData", dataS, ed);
    end
    if (w && !mis) mStore(s, z, a, d);
    @(negedge clk);
  endtask

  task automatic ld(input int s, input logic [1:0] z, input logic u,
                    input logic [31:0] a);
    issue(s, 1, 0, z, u, a, 0, 2'b01, 0, 0, 5'd3, 1, 32'h4);
  endtask

  task automatic st(input int s, input logic [1:0] z,
                    input logic [31:0] a, input logic [31:0] d);
    issue(s, 0, 1, z, 0, a, d, 2'b00, 0, 0, 5'd0, 0, 32'h4);
  endtask

  task automatic bubble(input int s);
    sel = s; vld = 0; fl = 0;
    @(posedge clk);
    #1;
    chk("bubbleValid", 32'(validS), 32'd0);
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "Stall"}, 32'(stallS), 32'd0);
    chk({tag, "Valid"}, 32'(validS), 32'd0);
    chk({tag, "RegWr"}, 32'(rwS), 32'd0);
    chk({tag, "Reg"},   32'(regS), 32'd0);
    chk({tag, "Data"},  dataS, 32'd0);
    chk({tag, "Mis"},   32'(misS), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prior;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkReset("reset");
    end
    rst = 0;
    @(negedge clk);

    for (int s = 0; s < 3; s++)
      for (int wi = 0; wi < DEPTH; wi++)
        st(s, 2'b10, 32'(wi * 4), $urandom);

    st(0, 2'b10, 32'h10, 32'hDEAD_BEEF);
    ld(0, 2'b10, 0, 32'h10);
    chk("deadbeef", dataS, 32'hDEAD_BEEF);

    st(0, 2'b10, 32'h10, 32'h0);
    st(0, 2'b00, 32'h13, 32'h80);
    ld(0, 2'b00, 0, 32'h13);
    chk("lbSigned", dataS, 32'hFFFF_FF80);
    ld(0, 2'b00, 1, 32'h13);
    chk("lbUnsigned", dataS, 32'h0000_0080);
    ld(0, 2'b10, 0, 32'h10);
    chk("lwAfterSb", dataS, 32'h8000_0000);

    st(2, 2'b01, 32'h44, 32'h0000_9ABC);
    ld(2, 2'b01, 0, 32'h44);
    issue(2, 0, 0, 2'b00, 0, 32'h55, 0, 2'b00, 0, 0, 5'd9, 1, 32'h4);
    chk("aluAfterLoad", dataS, 32'h55);

    prior = {mm[1][8'h23], mm[1][8'h22], mm[1][8'h21], mm[1][8'h20]};
    sel = 1; vld = 1; rd = 0; wr = 1; sz = 2'b10; uns = 0;
    alu = 32'h20; wdat = 32'h1234; m2 = 0; luop = 0;
    regw = 0; wreg = 0; fl = 0;
    #1;
    chk("flushStall0", 32'(stallS), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("flushStall1", 32'(stallS), 32'd1);
    fl = 1;
    @(posedge clk);
    @(negedge clk);
    fl = 0;
    vld = 0;
    #1;
    chk("flushStallAfter", 32'(stallS), 32'd0);
    chk("flushValid", 32'(validS), 32'd0);
    ld(1, 2'b10, 0, 32'h20);
    chk("flushPrior", dataS, prior);

    issue(0, 0, 0, 2'b00, 0, 32'h4, 0, 2'b01, 1, 32'hABCD_0000,
          5'd7, 1, 32'h8);
    chk("lui", dataS, 32'hABCD_0000);

    issue(2, 0, 0, 2'b00, 0, 32'h77, 0, 2'b00, 0, 0, 5'd5, 1, 32'h4);
    prior = {mm[2][8'h33], mm[2][8'h32], mm[2][8'h31], mm[2][8'h30]};
    sel = 2; vld = 1; rd = 0; wr = 1; sz = 2'b10;
    alu = 32'h30; wdat = 32'h5555_5555; m2 = 0; luop = 0; regw = 1;
    #1;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    vld = 0;
    @(posedge clk);
    #1;
    checkReset("midRst");
    @(negedge clk);
    rst = 0;
    ld(2, 2'b10, 0, 32'h30);
    chk("rstDiscard", dataS, prior);

    st(0, 2'b10, 32'h20, 32'h1111_1111);
    st(0, 2'b10, 32'h22, 32'hCAFE_F00D);
    ld(0, 2'b10, 0, 32'h20);
`ifdef MEM_STAGE_MISALIGN_EN
    chk("misWordKept", dataS, 32'h1111_1111);
`else
    chk("misWordIdx8", dataS, 32'hCAFE_F00D);
`endif

    st(0, 2'b10, 32'h110, 32'h0BAD_F00D);
    ld(0, 2'b10, 0, 32'h10);
    chk("wrap", dataS, 32'h0BAD_F00D);

    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 60; k++) begin
        int kind;
        logic [31:0] a;
        logic [1:0] z;
        kind = $urandom_range(0, 5);
        a = $urandom & 32'h3FF;
        z = 2'($urandom_range(0, 3));
        case (kind)
          0: issue(s, 0, 0, 2'b00, 0, $urandom, 0, 2'b00, 0, 0,
                   5'($urandom), 1'($urandom), $urandom);
          1: issue(s, 1, 0, z, 1'($urandom), a, 0, 2'b01, 0, 0,
                   5'($urandom), 1, $urandom);
          2: issue(s, 0, 1, z, 0, a, $urandom, 2'b00, 0, 0,
                   5'($urandom), 0, $urandom);
          3: issue(s, 0, 0, 2'b00, 0, $urandom, 0, 2'($urandom), 1,
                   $urandom, 5'($urandom), 1, $urandom);
          4: issue(s, 0, 0, 2'b00, 0, $urandom, 0,
                   2'($urandom_range(2, 3)), 0, 0, 5'($urandom), 1,
                   $urandom);
          default: bubble(s);
        endcase
      end
    end

    vld = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
